// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide sync RAM.
// Ports: clk/rst, IF req/addr/cancel/rdata/done, MEM req/we/size/signed/
// addr/wdata/rdata/done, RAM addr/wr/wdata/rdata, busy.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int WORD_BYTES = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_req,
   input  logic [ADDR_W-1:0]         if_addr,
   input  logic                      if_cancel,
   output logic [8*WORD_BYTES-1:0]   if_rdata,
   output logic                      if_done,
   input  logic                      mem_req,
   input  logic                      mem_we,
   input  logic [1:0]                mem_size,
   input  logic                      mem_signed,
   input  logic [ADDR_W-1:0]         mem_addr,
   input  logic [8*WORD_BYTES-1:0]   mem_wdata,
   output logic [8*WORD_BYTES-1:0]   mem_rdata,
   output logic                      mem_done,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_wr,
   output logic [7:0]                ram_wdata,
   input  logic [7:0]                ram_rdata,
   output logic                      busy
);

   localparam int DATA_W = 8 * WORD_BYTES;
   localparam int IDX_W  = $clog2(WORD_BYTES);
   localparam int WAIT_W = $clog2(RD_LAT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ADDR = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR_BYTE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]        state_q,     state_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [IDX_W-1:0]  last_q,      last_d;
   logic [WAIT_W-1:0] wait_q,      wait_d;
   logic [ADDR_W-1:0] base_q,      base_d;
   logic              is_if_q,     is_if_d;
   logic [1:0]        size_q,      size_d;
   logic              signed_q,    signed_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic [DATA_W-1:0] buf_q,       buf_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_done_q,   if_done_d;
   logic              mem_done_q,  mem_done_d;

   logic [IDX_W-1:0]  last_grant;
   logic [DATA_W-1:0] buf_upd;
   logic [DATA_W-1:0] ext;
   logic              cancel;

   // MEM transactions never see the flush.
   assign cancel = is_if_q & if_cancel;

   always_comb begin
      last_grant = IDX_W'(WORD_BYTES - 1);
      unique case (mem_size)
         2'd0:    last_grant = '0;
         2'd1:    last_grant = IDX_W'(1);
         default: ;
      endcase
   end

   always_comb begin
      buf_upd = buf_q;
      buf_upd[{idx_q, 3'b000} +: 8] = ram_rdata;
   end

   // Upper bytes are zero from the grant; only the fill bit varies.
   always_comb begin
      ext = buf_upd;
      unique case (size_q)
         2'd0: begin
            for (int i = 8; i < DATA_W; i++)
               ext[i] = signed_q & buf_upd[7];
         end
         2'd1: begin
            for (int i = 16; i < DATA_W; i++)
               ext[i] = signed_q & buf_upd[15];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      wait_d      = wait_q;
      base_d      = base_q;
      is_if_d     = is_if_q;
      size_d      = size_q;
      signed_d    = signed_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            idx_d = '0;
            buf_d = '0;
            if (mem_req) begin
               base_d   = mem_addr;
               size_d   = mem_size;
               signed_d = mem_signed;
               wdata_d  = mem_wdata;
               last_d   = last_grant;
               is_if_d  = 1'b0;
               state_d  = mem_we ? S_WR_BYTE : S_RD_ADDR;
            end else if (if_req && !if_cancel) begin
               base_d   = if_addr;
               size_d   = 2'd2;
               signed_d = 1'b0;
               last_d   = IDX_W'(WORD_BYTES - 1);
               is_if_d  = 1'b1;
               state_d  = S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               wait_d  = WAIT_W'(RD_LAT);
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (cancel) begin
               wait_d  = '0;
               state_d = S_IDLE;
            end else if (wait_q == WAIT_W'(1)) begin
               wait_d = '0;
               buf_d  = buf_upd;
               if (idx_q == last_q) begin
                  state_d = S_DONE;
                  if (is_if_q) begin
                     if_rdata_d = buf_upd;
                     if_done_d  = 1'b1;
                  end else begin
                     mem_rdata_d = ext;
                     mem_done_d  = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_RD_ADDR;
               end
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         S_WR_BYTE: begin
            if (idx_q == last_q) begin
               mem_done_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         last_q      <= '0;
         wait_q      <= '0;
         base_q      <= '0;
         is_if_q     <= 1'b0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         wdata_q     <= '0;
         buf_q       <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         wait_q      <= wait_d;
         base_q      <= base_d;
         is_if_q     <= is_if_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

   logic active;
   assign active = (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT) ||
                   (state_q == S_WR_BYTE);

   // Address stays on the bus through the wait so RAM pipelines see it.
   assign ram_addr  = active ? base_q + ADDR_W'(idx_q) : '0;
   assign ram_wr    = (state_q == S_WR_BYTE);
   assign ram_wdata = ram_wr ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
   assign busy      = (state_q != S_IDLE);
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_done   = if_done_q;
   assign mem_done  = mem_done_q;

endmodule
